// File: rtl/ibuf_queue_if.sv
// Fetch-to-decode instruction buffer bus: four fetch lanes in, two decode slots out.
// slave  = buffer side (takes lanes, drives allowIn and decode slots).
// master = environment side (drives lanes and decode allowIn).
interface ibuf_queue_if;
  logic        ifu_instA_valid, ifu_instB_valid, ifu_instC_valid, ifu_instD_valid;
  logic        ifu_instA_allowIn, ifu_instB_allowIn, ifu_instC_allowIn, ifu_instD_allowIn;
  logic [31:0] ifu_instA_data, ifu_instB_data, ifu_instC_data, ifu_instD_data;
  logic        idu_inst0_valid, idu_inst0_allowIn;
  logic [31:0] idu_inst0_data;
  logic        idu_inst1_valid, idu_inst1_allowIn;
  logic [31:0] idu_inst1_data;

  modport slave (
    input  ifu_instA_valid, ifu_instB_valid, ifu_instC_valid, ifu_instD_valid,
    input  ifu_instA_data, ifu_instB_data, ifu_instC_data, ifu_instD_data,
    output ifu_instA_allowIn, ifu_instB_allowIn, ifu_instC_allowIn, ifu_instD_allowIn,
    output idu_inst0_valid, idu_inst0_data, idu_inst1_valid, idu_inst1_data,
    input  idu_inst0_allowIn, idu_inst1_allowIn
  );

  modport master (
    output ifu_instA_valid, ifu_instB_valid, ifu_instC_valid, ifu_instD_valid,
    output ifu_instA_data, ifu_instB_data, ifu_instC_data, ifu_instD_data,
    input  ifu_instA_allowIn, ifu_instB_allowIn, ifu_instC_allowIn, ifu_instD_allowIn,
    input  idu_inst0_valid, idu_inst0_data, idu_inst1_valid, idu_inst1_data,
    output idu_inst0_allowIn, idu_inst1_allowIn
  );
endinterface

// File: rtl/ibuf_queue.sv
// In-order circular instruction buffer: 4 compacted fetch lanes in, 2 decode slots out; flush on redirect.
// Latency: an entry written in cycle N is visible on idu_inst0 in cycle N+1 (no bypass).
// Backpressure: lane k allowIn = free>=k+1 from registered count (gated by flush/rst); optional stats under IBUF_STAT_EN.
module ibuf_queue #(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  ibuf_queue_if.slave  q
`ifdef IBUF_STAT_EN
  ,
  output logic [31:0]  stat_full_cycles,
  output logic [31:0]  stat_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_p1;
  logic [PTR_W:0]   count_q, count_d, free;
  logic [3:0]       lane_vld, lane_allow, lane_fire;
  logic [31:0]      lane_dat [4];
  logic [PTR_W-1:0] lane_addr [4];
  logic [2:0]       enq_num;
  logic             v0, v1, d0, d1;
  logic [1:0]       deq_num;

  assign lane_vld    = {q.ifu_instD_valid, q.ifu_instC_valid, q.ifu_instB_valid, q.ifu_instA_valid};
  assign lane_dat[0] = q.ifu_instA_data;
  assign lane_dat[1] = q.ifu_instB_data;
  assign lane_dat[2] = q.ifu_instC_data;
  assign lane_dat[3] = q.ifu_instD_data;
  assign free        = DEPTH_C - count_q;

  // Lane acceptance depends only on last cycle's occupancy; flush and reset are the only live gates.
  always_comb begin
    lane_allow = '0;
    for (int k = 0; k < 4; k++) begin
      lane_allow[k] = (free >= (PTR_W+1)'(k + 1)) & ~flush & ~rst;
    end
  end

  assign lane_fire           = lane_vld & lane_allow;
  assign q.ifu_instA_allowIn = lane_allow[0];
  assign q.ifu_instB_allowIn = lane_allow[1];
  assign q.ifu_instC_allowIn = lane_allow[2];
  assign q.ifu_instD_allowIn = lane_allow[3];

  // Pack fired lanes in A..D order into consecutive slots, skipping lanes that did not fire.
  always_comb begin
    enq_num = '0;
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = wr_ptr_q + PTR_W'(enq_num);
      enq_num      = enq_num + {2'b00, lane_fire[k]};
    end
  end

  assign v0        = (count_q != '0);
  assign v1        = (count_q >= (PTR_W+1)'(2));
  assign d0        = v0 & q.idu_inst0_allowIn;
  assign d1        = d0 & v1 & q.idu_inst1_allowIn;
  assign deq_num   = {1'b0, d0} + {1'b0, d1};
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  assign q.idu_inst0_valid = v0;
  assign q.idu_inst1_valid = v1;
  assign q.idu_inst0_data  = mem_q[rd_ptr_q];
  assign q.idu_inst1_data  = mem_q[rd_ptr_p1];

  // Pointer/count advance; flush overrides everything and returns the queue to its origin.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(deq_num);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_num);
    count_d  = count_q + (PTR_W+1)'(enq_num) - (PTR_W+1)'(deq_num);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Queue control registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; entries are only read when covered by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_fire[k]) mem_q[lane_addr[k]] <= lane_dat[k];
    end
  end

`ifdef IBUF_STAT_EN
  logic [31:0] full_cnt_q, stall_cnt_q;

  // Occupancy/stall counters survive flush and wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (count_q == DEPTH_C) full_cnt_q <= full_cnt_q + 32'd1;
      if (|(lane_vld & ~lane_allow)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_full_cycles  = full_cnt_q;
  assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ibuf_queue.sv
// Directed + random bench for ibuf_queue against a queue-based reference model.
module tb_ibuf_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  ibuf_queue_if bus();
`ifdef IBUF_STAT_EN
  logic [31:0] stat_full, stat_stall;
`endif

  ibuf_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .q(bus)
`ifdef IBUF_STAT_EN
    ,
    .stat_full_cycles(stat_full),
    .stat_stall_cycles(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] mq[$];
  int m_full  = 0;
  int m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic set_ifu(input logic [3:0] v, input logic [31:0] a, b, c, d);
    bus.ifu_instA_valid = v[0]; bus.ifu_instB_valid = v[1];
    bus.ifu_instC_valid = v[2]; bus.ifu_instD_valid = v[3];
    bus.ifu_instA_data = a; bus.ifu_instB_data = b;
    bus.ifu_instC_data = c; bus.ifu_instD_data = d;
  endtask

  task automatic set_idu(input logic a0, input logic a1);
    bus.idu_inst0_allowIn = a0;
    bus.idu_inst1_allowIn = a1;
  endtask

  function automatic logic m_allow(input int k);
    return ((DEPTH - mq.size()) >= (k + 1)) && !flush;
  endfunction

  function automatic logic [3:0] cur_vld();
    return {bus.ifu_instD_valid, bus.ifu_instC_valid, bus.ifu_instB_valid, bus.ifu_instA_valid};
  endfunction

  task automatic compare();
    logic [3:0] al;
    al = {bus.ifu_instD_allowIn, bus.ifu_instC_allowIn, bus.ifu_instB_allowIn, bus.ifu_instA_allowIn};
    for (int k = 0; k < 4; k++) chk1($sformatf("allow%0d", k), al[k], m_allow(k));
    chk1("v0", bus.idu_inst0_valid, mq.size() >= 1);
    chk1("v1", bus.idu_inst1_valid, mq.size() >= 2);
    if (mq.size() >= 1) chk("d0", bus.idu_inst0_data, mq[0]);
    if (mq.size() >= 2) chk("d1", bus.idu_inst1_data, mq[1]);
`ifdef IBUF_STAT_EN
    chk("stat_full", stat_full, 32'(m_full));
    chk("stat_stall", stat_stall, 32'(m_stall));
`endif
  endtask

  // Reference behaviour at a clock edge: pops from the front, pushes accepted lanes in lane order.
  task automatic model_update();
    int sz;
    logic [3:0] v, al;
    logic [31:0] dat[4];
    logic e0, e1;
    sz = mq.size();
    v  = cur_vld();
    for (int k = 0; k < 4; k++) al[k] = m_allow(k);
    dat[0] = bus.ifu_instA_data; dat[1] = bus.ifu_instB_data;
    dat[2] = bus.ifu_instC_data; dat[3] = bus.ifu_instD_data;
    if (sz == DEPTH) m_full++;
    if ((v & ~al) != 4'b0) m_stall++;
    if (flush) begin
      mq.delete();
    end else begin
      e0 = (sz >= 1) && bus.idu_inst0_allowIn;
      e1 = e0 && (sz >= 2) && bus.idu_inst1_allowIn;
      if (e0) void'(mq.pop_front());
      if (e1) void'(mq.pop_front());
      for (int k = 0; k < 4; k++) if (v[k] && al[k]) mq.push_back(dat[k]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_allow(input string tag, input logic [3:0] exp);
    chk1({tag, "_A"}, bus.ifu_instA_allowIn, exp[0]);
    chk1({tag, "_B"}, bus.ifu_instB_allowIn, exp[1]);
    chk1({tag, "_C"}, bus.ifu_instC_allowIn, exp[2]);
    chk1({tag, "_D"}, bus.ifu_instD_allowIn, exp[3]);
  endtask

  initial begin
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b0, 1'b0);
    #3;
    chk_allow("rst", 4'h0);
    chk1("rst_v0", bus.idu_inst0_valid, 1'b0);
    chk1("rst_v1", bus.idu_inst1_valid, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    cycle();

    // Fill and drain
    set_ifu(4'hF, 32'h100, 32'h101, 32'h102, 32'h103); cycle();
    set_ifu(4'hF, 32'h104, 32'h105, 32'h106, 32'h107); cycle();
    set_ifu(4'hF, 32'h108, 32'h109, 32'h10A, 32'h10B);
    chk_allow("full", 4'h0);
    cycle();
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_d0", i), bus.idu_inst0_data, 32'h100 + 32'(2 * i));
      chk($sformatf("drain%0d_d1", i), bus.idu_inst1_data, 32'h101 + 32'(2 * i));
      cycle();
    end
    chk1("empty_v0", bus.idu_inst0_valid, 1'b0);
    chk_allow("empty", 4'hF);

    // Partial acceptance at count 6
    set_idu(1'b0, 1'b0);
    set_ifu(4'hF, 32'h200, 32'h201, 32'h202, 32'h203); cycle();
    set_ifu(4'h3, 32'h204, 32'h205, 32'h0, 32'h0); cycle();
    set_ifu(4'hF, 32'h206, 32'h207, 32'h208, 32'h209);
    chk_allow("cnt6", 4'h3);
    cycle();
    chk_allow("cnt8", 4'h0);
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b1, 1'b1);
    repeat (4) cycle();

    // Compaction across the wrap point, then a 2-read straddling it
    set_idu(1'b0, 1'b0);
    set_ifu(4'hF, 32'h300, 32'h301, 32'h302, 32'h303); cycle();
    set_ifu(4'h3, 32'h304, 32'h305, 32'h0, 32'h0); cycle();
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b1, 1'b1);
    repeat (3) cycle();
    set_idu(1'b0, 1'b0);
    set_ifu(4'b0101, 32'hAA, 32'hBB, 32'hCC, 32'hDD); cycle();
    chk("cmp_d0", bus.idu_inst0_data, 32'hAA);
    chk("cmp_d1", bus.idu_inst1_data, 32'hCC);
    set_ifu(4'b0001, 32'hDD, 32'h0, 32'h0, 32'h0); cycle();
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b1, 1'b0); cycle();
    chk("wrap_d0", bus.idu_inst0_data, 32'hCC);
    chk("wrap_d1", bus.idu_inst1_data, 32'hDD);
    set_idu(1'b1, 1'b1); cycle();

    // inst1 allowIn without inst0 consumes nothing
    set_idu(1'b0, 1'b0);
    set_ifu(4'b0111, 32'h400, 32'h401, 32'h402, 32'h403); cycle();
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b0, 1'b1); cycle();
    chk("i1only_d0", bus.idu_inst0_data, 32'h400);
    chk("i1only_d1", bus.idu_inst1_data, 32'h401);
    cycle();
    set_idu(1'b1, 1'b0);
    repeat (3) cycle();
    chk1("i1only_empty", bus.idu_inst0_valid, 1'b0);

    // Flush with traffic on both sides
    set_idu(1'b0, 1'b0);
    set_ifu(4'hF, 32'h500, 32'h501, 32'h502, 32'h503); cycle();
    set_ifu(4'h1, 32'h504, 32'h0, 32'h0, 32'h0); cycle();
    set_ifu(4'hF, 32'h510, 32'h511, 32'h512, 32'h513);
    set_idu(1'b1, 1'b1);
    flush = 1'b1;
    #1;
    chk_allow("flush", 4'h0);
    cycle();
    flush = 1'b0;
    set_ifu(4'h0, 0, 0, 0, 0);
    set_idu(1'b0, 1'b0);
    #1;
    chk1("postflush_v0", bus.idu_inst0_valid, 1'b0);
    chk1("postflush_v1", bus.idu_inst1_valid, 1'b0);
    chk_allow("postflush", 4'hF);
    cycle();

    // Asynchronous reset while holding 4 entries
    set_ifu(4'hF, 32'h600, 32'h601, 32'h602, 32'h603); cycle();
    set_ifu(4'h0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_allow("arst", 4'h0);
    chk1("arst_v0", bus.idu_inst0_valid, 1'b0);
    chk1("arst_v1", bus.idu_inst1_valid, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    mq.delete();
    m_full = 0;
    m_stall = 0;
    #1;
    chk1("rel_v0", bus.idu_inst0_valid, 1'b0);
    chk_allow("rel", 4'hF);
`ifdef IBUF_STAT_EN
    chk("rel_stat_full", stat_full, 32'h0);
    chk("rel_stat_stall", stat_stall, 32'h0);
`endif
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_ifu(4'($urandom), $urandom, $urandom, $urandom, $urandom);
      set_idu($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
